seq_serializer: RTL and testbench
=================================

// Module: seq_serializer
// PURPOSE
//   Parallel-to-serial bit-stream source for the detect_1011 sequence detector.
//   - Accepts words through a valid/ready handshake and emits them one bit per clock on seq_o, MSB first.
//   - seq_o connects directly to the detector's seq_i.
//   - Supports back-to-back words with no gap (one-word shadow buffer) and a loop mode for repeated patterns.
// PARAMETERS
//   DATA_W   8                  maximum word length in bits (>=2)
//   LEN_W    $clog2(DATA_W+1)   width of len_i (localparam, derived)
// PORTS
//   clk_i      in   1       clock, rising edge
//   rst_n_i    in   1       asynchronous active-low reset
//   data_i     in   DATA_W  word to send; low len bits used
//   len_i      in   LEN_W   bits in word; 0 or >DATA_W => DATA_W
//   loop_i     in   1       sampled with word: repeat it until stop_i
//   valid_i    in   1       word offered
//   ready_o    out  1       word accepted on clk edge when valid_i&ready_o
//   stop_i     in   1       end loop after the current repetition
//   seq_o      out  1       serial bit (to detector seq_i)
//   seq_vld_o  out  1       seq_o carries a payload bit this cycle
//   busy_o     out  1       FSM not IDLE
//   done_o     out  1       1-cycle pulse coincident with the last bit of a non-repeating word
// BEHAVIOUR
//   - Reset (async, any state): seq_o=0, seq_vld_o=0, busy_o=0, done_o=0, ready_o=1.
//     Shift register, bit counter and shadow buffer are cleared. A partly sent word is discarded.
//   - FSM states:
//     - IDLE: ready_o=1. On accept, load shift register and go to SHIFT.
//     - SHIFT: a new bit is registered on each clock; the counter counts down from len-1.
//   - Latency: accept on edge N -> first bit (data_i[len-1]) valid in cycle N+1.
//     The last bit (data_i[0]) is valid in cycle N+len.
//   - seq_o/seq_vld_o are registered outputs. When seq_vld_o=0, seq_o=0.
//   - ready_o = (state==IDLE) | ~pend_vld. It is combinational from registers only and has no path from valid_i.
//   - An accept in SHIFT loads the shadow buffer (pend_vld=1). Data, length and loop flag are stored together.
//   - Word boundary (last bit on seq_o this cycle), in priority order:
//     1. pend_vld: the pending word starts next cycle with no gap; pend_vld clears.
//     2. Accept in this same cycle with pend_vld=0: the new word starts next cycle directly.
//     3. loop_q & ~stop_q: the same word restarts next cycle.
//     4. Otherwise: go to IDLE; seq_vld_o=0 next cycle.
//   - done_o=1 with the last bit only for boundary cases 1, 2 and 4 of a non-looping word.
//     It also fires on the final repetition of a looping word after stop.
//   - stop_i is sticky (stop_q) until the loop ends. It is ignored when no loop is active.
//     A stop at the boundary cycle itself takes effect at that boundary.
//   - A pending word pre-empts a loop at the next boundary; stop_q clears.
//   - len==1: one bit per word, boundary every cycle, back-to-back works.
//   - busy_o=1 in SHIFT, including loop repetitions.
// STRUCTURE
//   - Shared include seq_defs.vh holds:
//     - state encodings (ST_IDLE, ST_SHIFT);
//     - the len-normalise rule as a function (0 or >DATA_W -> DATA_W).
//   - The same include is used by detect_1011 benches.
//   - No sub-module: keep the design flat. It contains the FSM, the DATA_W shift register with down-counter,
//     a one-entry shadow buffer, and the loop/stop flags.
// TESTING (DATA_W=8; also wire seq_o -> detect_1011.seq_i)
//   1. rst_n_i=0 for 43ns -> seq_o=0, seq_vld_o=0, busy_o=0, done_o=0, ready_o=1; outputs hold until first valid_i.
//   2. Accept data_i=8'h0B, len_i=4 at edge N -> seq_o=1,0,1,1 in cycles N+1..N+4, done_o at N+4,
//      idle at N+5; detector out_o pulses once.
//   3. Offer 8'hA5, 8'h3C, 8'hFF back-to-back (valid_i held) -> 24 contiguous bits
//      (10100101 00111100 11111111); ready_o=0 from the cycle after the 2nd accept until the 1st boundary.
//   4. Accept data_i=6'b110110, len_i=6, loop_i=1; pulse stop_i during 3rd repetition -> exactly 18 bits,
//      done_o on bit 18, then idle.
//   5. len_i=0 with 8'hC3 -> 8 bits 11000011; len_i=1 with three words 1,0,1 -> seq_o=1,0,1 on consecutive cycles.
//   6. Assert rst_n_i on bit 3 of a word with pend_vld=1 -> outputs to reset values immediately, pending word lost;
//      after release, a new accept streams correctly.

Source files
------------

// File: rtl/seq_serializer_pkg.sv
// Shared state encoding and length rule for the seq_serializer bit-stream source.
package seq_serializer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // A length of zero, or one beyond the word width, means "send the whole word".
    function automatic int unsigned norm_len(input int unsigned len_raw, input int unsigned max_len);
        int unsigned len_n;
        if ((len_raw == 32'd0) || (len_raw > max_len)) begin
            len_n = max_len;
        end else begin
            len_n = len_raw;
        end
        return len_n;
    endfunction

endpackage

// File: rtl/seq_serializer_if.sv
// Word handshake and serial stream bundle; _i/_o suffixes are from the serializer's point of view.
interface seq_serializer_if #(
    parameter int DATA_W = 8
);
    localparam int LEN_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] data_i;
    logic [LEN_W-1:0]  len_i;
    logic              loop_i;
    logic              valid_i;
    logic              ready_o;
    logic              stop_i;
    logic              seq_o;
    logic              seq_vld_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        output data_i, len_i, loop_i, valid_i, stop_i,
        input  ready_o, seq_o, seq_vld_o, busy_o, done_o
    );

    modport slave (
        input  data_i, len_i, loop_i, valid_i, stop_i,
        output ready_o, seq_o, seq_vld_o, busy_o, done_o
    );

endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial source: MSB-first bit stream with a one-word shadow buffer and loop mode.
module seq_serializer
    import seq_serializer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input logic             clk_i,
    input logic             rst_n_i,
    seq_serializer_if.slave bus
);

    localparam int LEN_W = $clog2(DATA_W + 1);

    state_e            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] word_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  len_q;
    logic              loop_q;
    logic              stop_q;
    logic [DATA_W-1:0] pend_word_q;
    logic [LEN_W-1:0]  pend_len_q;
    logic              pend_loop_q;
    logic              pend_vld_q;
    logic              seq_q;
    logic              seq_vld_q;

    logic              ready_s;
    logic              accept_s;
    logic              last_s;
    logic              stop_eff_s;
    logic              load_s;
    logic [LEN_W-1:0]  in_len_s;
    logic [DATA_W-1:0] in_word_s;
    logic [LEN_W-1:0]  ld_len_s;
    logic [DATA_W-1:0] ld_word_s;
    logic              ld_loop_s;

    // Handshake, word-boundary detection and selection of the next word to start.
    always_comb begin
        in_len_s   = LEN_W'(norm_len(32'(bus.len_i), 32'(DATA_W)));
        // Words are stored MSB-aligned so the outgoing bit is always the top bit.
        in_word_s  = bus.data_i << (LEN_W'(DATA_W) - in_len_s);
        ready_s    = (state_q == ST_IDLE) | ~pend_vld_q;
        accept_s   = bus.valid_i & ready_s;
        last_s     = (state_q == ST_SHIFT) && (cnt_q == {LEN_W{1'b0}});
        stop_eff_s = stop_q | bus.stop_i;

        if ((state_q == ST_SHIFT) && pend_vld_q) begin
            ld_word_s = pend_word_q;
            ld_len_s  = pend_len_q;
            ld_loop_s = pend_loop_q;
        end else if (accept_s) begin
            ld_word_s = in_word_s;
            ld_len_s  = in_len_s;
            ld_loop_s = bus.loop_i;
        end else begin
            ld_word_s = word_q;
            ld_len_s  = len_q;
            ld_loop_s = loop_q;
        end

        if (state_q == ST_IDLE) begin
            load_s = accept_s;
        end else begin
            load_s = last_s & (pend_vld_q | accept_s | (loop_q & ~stop_eff_s));
        end
    end

    // FSM, shift register, down-counter, shadow buffer and loop/stop flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            shift_q     <= {DATA_W{1'b0}};
            word_q      <= {DATA_W{1'b0}};
            cnt_q       <= {LEN_W{1'b0}};
            len_q       <= {LEN_W{1'b0}};
            loop_q      <= 1'b0;
            stop_q      <= 1'b0;
            pend_word_q <= {DATA_W{1'b0}};
            pend_len_q  <= {LEN_W{1'b0}};
            pend_loop_q <= 1'b0;
            pend_vld_q  <= 1'b0;
            seq_q       <= 1'b0;
            seq_vld_q   <= 1'b0;
        end else begin
            if (load_s) begin
                state_q   <= ST_SHIFT;
                word_q    <= ld_word_s;
                len_q     <= ld_len_s;
                loop_q    <= ld_loop_s;
                shift_q   <= {ld_word_s[DATA_W-2:0], 1'b0};
                cnt_q     <= ld_len_s - LEN_W'(1'b1);
                seq_q     <= ld_word_s[DATA_W-1];
                seq_vld_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_SHIFT: begin
                        if (last_s) begin
                            state_q   <= ST_IDLE;
                            loop_q    <= 1'b0;
                            seq_q     <= 1'b0;
                            seq_vld_q <= 1'b0;
                        end else begin
                            shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                            cnt_q   <= cnt_q - LEN_W'(1'b1);
                            seq_q   <= shift_q[DATA_W-1];
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        loop_q    <= 1'b0;
                        seq_q     <= 1'b0;
                        seq_vld_q <= 1'b0;
                    end
                endcase
            end

            // An accept on the boundary cycle bypasses the shadow buffer and starts directly.
            if (accept_s && (state_q == ST_SHIFT) && !last_s) begin
                pend_word_q <= in_word_s;
                pend_len_q  <= in_len_s;
                pend_loop_q <= bus.loop_i;
                pend_vld_q  <= 1'b1;
            end else if (last_s && pend_vld_q) begin
                pend_vld_q <= 1'b0;
            end else begin
                pend_vld_q <= pend_vld_q;
            end

            if (last_s || (state_q != ST_SHIFT)) begin
                stop_q <= 1'b0;
            end else if (loop_q && bus.stop_i) begin
                stop_q <= 1'b1;
            end else begin
                stop_q <= stop_q;
            end
        end
    end

    assign bus.ready_o   = ready_s;
    assign bus.seq_o     = seq_q;
    assign bus.seq_vld_o = seq_vld_q;
    assign bus.busy_o    = (state_q == ST_SHIFT);
    assign bus.done_o    = last_s & (~loop_q | stop_eff_s);

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: directed scenarios plus randomized words against a stream model.
module tb_seq_serializer;

    localparam int DW = 8;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    seq_serializer_if #(.DATA_W(DW)) bus ();
    seq_serializer #(.DATA_W(DW)) dut (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus));

    int   n_checks = 0;
    int   n_pass   = 0;
    logic mon_on   = 1'b0;
    logic obs_seq[$];
    logic obs_vld[$];
    logic obs_done[$];
    logic obs_rdy[$];
    logic obs_busy[$];
    logic exp_bits[$];
    logic exp_done[$];
    logic got_bits[$];
    logic got_done[$];
    int   got_stray;

    // one sample per cycle, taken on the falling edge
    always @(negedge clk_i) begin
        if (mon_on) begin
            obs_seq.push_back(bus.seq_o);
            obs_vld.push_back(bus.seq_vld_o);
            obs_done.push_back(bus.done_o);
            obs_rdy.push_back(bus.ready_o);
            obs_busy.push_back(bus.busy_o);
        end
    end

    function automatic int eff_len(input int l);
        return ((l == 0) || (l > DW)) ? DW : l;
    endfunction

    // Expected stream: the low eff_len bits MSB first, repeated reps times; done on the very last bit.
    function automatic void model_word(input logic [DW-1:0] d, input int l, input int reps);
        int n;
        n = eff_len(l);
        for (int r = 0; r < reps; r++) begin
            for (int i = n - 1; i >= 0; i--) begin
                exp_bits.push_back(d[i]);
                exp_done.push_back((r == reps - 1) && (i == 0));
            end
        end
    endfunction

    function automatic void collect(input int from);
        got_bits.delete();
        got_done.delete();
        got_stray = 0;
        for (int k = from; k < obs_vld.size(); k++) begin
            if (obs_vld[k] === 1'b1) begin
                got_bits.push_back(obs_seq[k]);
                got_done.push_back(obs_done[k]);
            end else if (obs_done[k] !== 1'b0) begin
                got_stray++;
            end
        end
    endfunction

    function automatic int stream_diff();
        int diff;
        diff = (got_bits.size() > exp_bits.size()) ? (got_bits.size() - exp_bits.size())
                                                   : (exp_bits.size() - got_bits.size());
        for (int i = 0; (i < got_bits.size()) && (i < exp_bits.size()); i++) begin
            if ((got_bits[i] !== exp_bits[i]) || (got_done[i] !== exp_done[i])) diff++;
        end
        return diff + got_stray;
    endfunction

    // sel 0: seq_vld_o, 1: ready_o, otherwise busy_o
    function automatic int count_hi(input int sel, input int from, input int n);
        int   c;
        logic v;
        c = 0;
        for (int k = from; (k < from + n) && (k < obs_vld.size()); k++) begin
            case (sel)
                0:       v = obs_vld[k];
                1:       v = obs_rdy[k];
                default: v = obs_busy[k];
            endcase
            if (v === 1'b1) c++;
        end
        return c;
    endfunction

    // acc_idx is the sample index of the cycle ending in the accepting edge; first bit is at acc_idx+1.
    task automatic send_word(input logic [DW-1:0] d, input int l, input logic lp, output int acc_idx);
        int waited;
        waited  = 0;
        acc_idx = -1;
        bus.data_i  = d;
        bus.len_i   = l[3:0];
        bus.loop_i  = lp;
        bus.valid_i = 1'b1;
        while ((acc_idx < 0) && (waited < 100)) begin
            @(negedge clk_i); #1;
            if (bus.ready_o === 1'b1) acc_idx = obs_vld.size() - 1;
            @(posedge clk_i); #1;
            waited++;
        end
        bus.valid_i = 1'b0;
        bus.loop_i  = 1'b0;
        n_checks++;
        if (acc_idx < 0) begin
            $display("FAIL accept: word %0h still not taken after %0d cycles, need acceptance", d, waited);
            acc_idx = obs_vld.size() - 1;
        end else begin
            n_pass++;
        end
    endtask

    task automatic wait_idle();
        int waited;
        bit idle;
        waited = 0;
        idle   = 1'b0;
        while (!idle && (waited < 400)) begin
            @(negedge clk_i); #1;
            idle = (bus.busy_o === 1'b0);
            waited++;
        end
        @(posedge clk_i); #1;
        n_checks++;
        if (!idle) $display("FAIL idle_timeout: busy_o=%0b after %0d cycles, need 0", bus.busy_o, waited);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        #43;
        n_checks += 5;
        if (bus.seq_o !== 1'b0)     $display("FAIL rst_seq: got %0b need 0", bus.seq_o);     else n_pass++;
        if (bus.seq_vld_o !== 1'b0) $display("FAIL rst_vld: got %0b need 0", bus.seq_vld_o); else n_pass++;
        if (bus.busy_o !== 1'b0)    $display("FAIL rst_busy: got %0b need 0", bus.busy_o);   else n_pass++;
        if (bus.done_o !== 1'b0)    $display("FAIL rst_done: got %0b need 0", bus.done_o);   else n_pass++;
        if (bus.ready_o !== 1'b1)   $display("FAIL rst_ready: got %0b need 1", bus.ready_o); else n_pass++;
        rst_n_i = 1'b1;
        mon_on  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i); #1;
            n_checks++;
            if ({bus.seq_vld_o, bus.busy_o, bus.done_o, bus.ready_o, bus.seq_o} !== 5'b00010)
                $display("FAIL hold_idle: got vld/busy/done/rdy/seq=%05b need 00010",
                         {bus.seq_vld_o, bus.busy_o, bus.done_o, bus.ready_o, bus.seq_o});
            else n_pass++;
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_single();
        int         a;
        logic [4:0] seq_pat;
        logic [4:0] vld_pat;
        logic [4:0] done_pat;
        seq_pat  = 5'b10110;
        vld_pat  = 5'b11110;
        done_pat = 5'b00010;
        send_word(8'h0B, 4, 1'b0, a);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i); #1;
            n_checks += 4;
            if (bus.seq_o !== seq_pat[4-k])
                $display("FAIL single_seq[N+%0d]: got %0b need %0b", k + 1, bus.seq_o, seq_pat[4-k]);
            else n_pass++;
            if (bus.seq_vld_o !== vld_pat[4-k])
                $display("FAIL single_vld[N+%0d]: got %0b need %0b", k + 1, bus.seq_vld_o, vld_pat[4-k]);
            else n_pass++;
            if (bus.done_o !== done_pat[4-k])
                $display("FAIL single_done[N+%0d]: got %0b need %0b", k + 1, bus.done_o, done_pat[4-k]);
            else n_pass++;
            if (bus.busy_o !== vld_pat[4-k])
                $display("FAIL single_busy[N+%0d]: got %0b need %0b", k + 1, bus.busy_o, vld_pat[4-k]);
            else n_pass++;
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_back_to_back();
        int a1, a2, a3, d;
        exp_bits.delete();
        exp_done.delete();
        send_word(8'hA5, 8, 1'b0, a1);
        send_word(8'h3C, 8, 1'b0, a2);
        send_word(8'hFF, 8, 1'b0, a3);
        model_word(8'hA5, 8, 1);
        model_word(8'h3C, 8, 1);
        model_word(8'hFF, 8, 1);
        wait_idle();
        collect(a1 + 1);
        d = stream_diff();
        n_checks += 6;
        if (d != 0) $display("FAIL b2b_stream: got %0d differing bits, need 0", d); else n_pass++;
        if (count_hi(0, a1 + 1, 24) != 24)
            $display("FAIL b2b_contig: got %0d valid cycles of 24, need 24", count_hi(0, a1 + 1, 24));
        else n_pass++;
        if (obs_vld[a1 + 25] !== 1'b0) $display("FAIL b2b_end: got vld=%0b need 0", obs_vld[a1 + 25]); else n_pass++;
        if (a2 != a1 + 1) $display("FAIL b2b_acc2: got cycle %0d need %0d", a2 - a1, 1); else n_pass++;
        if (count_hi(1, a1 + 2, 7) != 0)
            $display("FAIL b2b_ready_low: got %0d ready cycles, need 0", count_hi(1, a1 + 2, 7));
        else n_pass++;
        if (a3 != a1 + 9) $display("FAIL b2b_acc3: got cycle %0d need %0d", a3 - a1, 9); else n_pass++;
    endtask

    task automatic test_loop();
        int a, d;
        exp_bits.delete();
        exp_done.delete();
        send_word(8'h36, 6, 1'b1, a);
        repeat (13) begin @(posedge clk_i); #1; end
        bus.stop_i = 1'b1;
        @(posedge clk_i); #1;
        bus.stop_i = 1'b0;
        wait_idle();
        model_word(8'h36, 6, 3);
        collect(a + 1);
        d = stream_diff();
        n_checks += 4;
        if (d != 0) $display("FAIL loop_stream: got %0d differing bits, need 0", d); else n_pass++;
        if (count_hi(0, a + 1, 18) != 18)
            $display("FAIL loop_contig: got %0d valid cycles, need 18", count_hi(0, a + 1, 18));
        else n_pass++;
        if (count_hi(2, a + 1, 18) != 18)
            $display("FAIL loop_busy: got %0d busy cycles, need 18", count_hi(2, a + 1, 18));
        else n_pass++;
        if (obs_busy[a + 19] !== 1'b0) $display("FAIL loop_idle: got busy=%0b need 0", obs_busy[a + 19]); else n_pass++;
    endtask

    task automatic test_len_edge();
        int a1, a2, a3, a4, d;
        exp_bits.delete();
        exp_done.delete();
        send_word(8'hC3, 0, 1'b0, a1);
        model_word(8'hC3, 0, 1);
        wait_idle();
        collect(a1 + 1);
        d = stream_diff();
        n_checks++;
        if (d != 0) $display("FAIL len0_stream: got %0d differing bits, need 0", d); else n_pass++;

        exp_bits.delete();
        exp_done.delete();
        send_word(8'h01, 1, 1'b0, a1);
        send_word(8'h00, 1, 1'b0, a2);
        send_word(8'h01, 1, 1'b0, a3);
        model_word(8'h01, 1, 1);
        model_word(8'h00, 1, 1);
        model_word(8'h01, 1, 1);
        wait_idle();
        send_word(8'h5A, 12, 1'b0, a4);
        model_word(8'h5A, 12, 1);
        wait_idle();
        collect(a1 + 1);
        d = stream_diff();
        n_checks += 3;
        if (d != 0) $display("FAIL len1_long_stream: got %0d differing bits, need 0", d); else n_pass++;
        if ((a2 != a1 + 1) || (a3 != a1 + 2))
            $display("FAIL len1_b2b_accept: got offsets %0d,%0d need 1,2", a2 - a1, a3 - a1);
        else n_pass++;
        if (count_hi(0, a1 + 1, 3) != 3)
            $display("FAIL len1_contig: got %0d valid cycles, need 3", count_hi(0, a1 + 1, 3));
        else n_pass++;
    endtask

    task automatic test_random();
        int          a, first, d, gap, l, lfull, s, reps;
        logic [DW-1:0] dat;
        exp_bits.delete();
        exp_done.delete();
        first = 0;
        for (int w = 0; w < 40; w++) begin
            dat        = DW'($urandom());
            l          = $urandom_range(0, 15);
            bus.stop_i = 1'($urandom_range(0, 1));
            send_word(dat, l, 1'b0, a);
            if (w == 0) first = a + 1;
            model_word(dat, l, 1);
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk_i); #1; end
        end
        bus.stop_i = 1'b0;
        wait_idle();
        collect(first);
        d = stream_diff();
        n_checks++;
        if (d != 0) $display("FAIL rand_stream: got %0d differing bits, need 0", d); else n_pass++;

        for (int t = 0; t < 5; t++) begin
            exp_bits.delete();
            exp_done.delete();
            dat   = DW'($urandom());
            l     = $urandom_range(0, 15);
            lfull = eff_len(l);
            s     = $urandom_range(1, 3 * lfull);
            reps  = (s + lfull - 1) / lfull;
            send_word(dat, l, 1'b1, a);
            repeat (s - 1) begin @(posedge clk_i); #1; end
            bus.stop_i = 1'b1;
            @(posedge clk_i); #1;
            bus.stop_i = 1'b0;
            wait_idle();
            model_word(dat, l, reps);
            collect(a + 1);
            d = stream_diff();
            n_checks += 2;
            if (d != 0) $display("FAIL rand_loop_stream: len %0d stop@%0d got %0d differing bits, need 0", lfull, s, d);
            else n_pass++;
            if (count_hi(0, a + 1, reps * lfull) != reps * lfull)
                $display("FAIL rand_loop_contig: got %0d valid cycles, need %0d", count_hi(0, a + 1, reps * lfull), reps * lfull);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midword();
        int a, b, idx, d;
        send_word(8'hA5, 8, 1'b0, a);
        send_word(8'h3C, 8, 1'b0, b);
        @(posedge clk_i); #1;
        @(negedge clk_i); #1;
        rst_n_i = 1'b0;
        #1;
        n_checks += 5;
        if (bus.seq_o !== 1'b0)     $display("FAIL mid_rst_seq: got %0b need 0", bus.seq_o);     else n_pass++;
        if (bus.seq_vld_o !== 1'b0) $display("FAIL mid_rst_vld: got %0b need 0", bus.seq_vld_o); else n_pass++;
        if (bus.busy_o !== 1'b0)    $display("FAIL mid_rst_busy: got %0b need 0", bus.busy_o);   else n_pass++;
        if (bus.done_o !== 1'b0)    $display("FAIL mid_rst_done: got %0b need 0", bus.done_o);   else n_pass++;
        if (bus.ready_o !== 1'b1)   $display("FAIL mid_rst_ready: got %0b need 1", bus.ready_o); else n_pass++;
        @(posedge clk_i); #3;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        idx = obs_vld.size();
        repeat (4) begin @(negedge clk_i); #1; end
        n_checks++;
        if (count_hi(0, idx, 4) != 0)
            $display("FAIL mid_rst_pending_lost: got %0d valid cycles, need 0", count_hi(0, idx, 4));
        else n_pass++;
        @(posedge clk_i); #1;
        exp_bits.delete();
        exp_done.delete();
        send_word(8'h96, 8, 1'b0, a);
        model_word(8'h96, 8, 1);
        wait_idle();
        collect(a + 1);
        d = stream_diff();
        n_checks++;
        if (d != 0) $display("FAIL mid_rst_restart: got %0d differing bits, need 0", d); else n_pass++;
    endtask

    initial begin
        bus.data_i  = 8'h00;
        bus.len_i   = 4'd0;
        bus.loop_i  = 1'b0;
        bus.valid_i = 1'b0;
        bus.stop_i  = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_loop();
        test_len_edge();
        test_random();
        test_reset_midword();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
